// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - mode encoding and lane constants for register_universal
package register_pkg;

    localparam int LANE_WIDTH = 8;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_INC  = 3'b010,
        MODE_DEC  = 3'b011,
        MODE_SHL  = 3'b100,
        MODE_SHR  = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_ROR  = 3'b111
    } mode_t;

endpackage

// File: rtl/register_byte_lane.sv
// rtl/register_byte_lane.sv - one 8-bit storage lane with enable and sync active-low clear
module register_byte_lane
    import register_pkg::*;
#(
    parameter logic [LANE_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  enable,
    input  logic [LANE_WIDTH-1:0] next,
    output logic [LANE_WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= next;
        end
    end

endmodule

// File: rtl/register_universal.sv
// rtl/register_universal.sv - universal CPU register (load/inc/dec/shift/rotate); option REGISTER_UNIVERSAL_SHADOW_EN
module register_universal
    import register_pkg::*;
#(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  clock_enable,
    input  logic [2:0]            mode,
    input  logic [WIDTH/8-1:0]    byte_en,
    input  logic [WIDTH-1:0]      d,
    input  logic                  serial_in,
`ifdef REGISTER_UNIVERSAL_SHADOW_EN
    input  logic                  save,
    input  logic                  restore,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  carry_out,
    output logic                  zero
);

    localparam int LANES = WIDTH / LANE_WIDTH;

    if ((WIDTH % LANE_WIDTH) != 0 || WIDTH < LANE_WIDTH) begin : g_bad_width
        $error("register_universal: WIDTH must be a non-zero multiple of 8");
    end

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    mode_t            op;
    logic [WIDTH:0]   sum_inc;
    logic [WIDTH:0]   sum_dec;
    logic [WIDTH-1:0] next_q;
    logic             next_carry;
    logic [LANES-1:0] lane_en;
    logic             restore_act;

    assign op      = mode_t'(mode);
    assign sum_inc = {1'b0, q} + ONE;
    assign sum_dec = {1'b0, q} - ONE;

`ifdef REGISTER_UNIVERSAL_SHADOW_EN
    logic [WIDTH-1:0] shadow;

    assign restore_act = restore;

    // Save captures the pre-update q, so save+restore naturally swaps.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            shadow <= RESET_VALUE;
        end else if (clock_enable && save) begin
            shadow <= q;
        end
    end
`else
    assign restore_act = 1'b0;
`endif

    always_comb begin
        next_q     = q;
        next_carry = carry_out;
        case (op)
            MODE_HOLD: begin
                next_q     = q;
                next_carry = carry_out;
            end
            MODE_LOAD: begin
                next_q     = d;
                next_carry = 1'b0;
            end
            MODE_INC: begin
                next_q     = sum_inc[WIDTH-1:0];
                next_carry = sum_inc[WIDTH];
            end
            MODE_DEC: begin
                next_q     = sum_dec[WIDTH-1:0];
                next_carry = sum_dec[WIDTH];
            end
            MODE_SHL: begin
                next_q     = {q[WIDTH-2:0], serial_in};
                next_carry = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q     = {serial_in, q[WIDTH-1:1]};
                next_carry = q[0];
            end
            MODE_ROL: begin
                next_q     = {q[WIDTH-2:0], q[WIDTH-1]};
                next_carry = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q     = {q[0], q[WIDTH-1:1]};
                next_carry = q[0];
            end
            default: begin
                next_q     = q;
                next_carry = carry_out;
            end
        endcase
`ifdef REGISTER_UNIVERSAL_SHADOW_EN
        if (restore_act) begin
            next_q     = shadow;
            next_carry = carry_out;
        end
`endif
    end

    // LOAD gates lanes by byte_en; every other operation rewrites the whole word.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_en[i] = clock_enable &&
                         (restore_act || (op != MODE_LOAD) || byte_en[i]);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        register_byte_lane #(
            .RESET_VALUE (RESET_VALUE[LANE_WIDTH*i +: LANE_WIDTH])
        ) u_lane (
            .clock   (clock),
            .clear_n (clear_n),
            .enable  (lane_en[i]),
            .next    (next_q[LANE_WIDTH*i +: LANE_WIDTH]),
            .q       (q[LANE_WIDTH*i +: LANE_WIDTH])
        );
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            carry_out <= 1'b0;
        end else if (clock_enable) begin
            carry_out <= next_carry;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_register_universal.sv
// tb/tb_register_universal.sv - directed scoreboard bench for register_universal
module tb_register_universal;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        clock_enable;
    logic [2:0]  mode;
    logic [1:0]  byte_en;
    logic [15:0] d;
    logic        serial_in;
    logic [15:0] q;
    logic        carry_out;
    logic        zero;
    logic [15:0] q1;
    logic        carry_out1;
    logic        zero1;
`ifdef REGISTER_UNIVERSAL_SHADOW_EN
    logic        save = 1'b0;
    logic        restore = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        c;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011,
                           SHL = 3'b100, SHR = 3'b101, ROL = 3'b110, ROR = 3'b111;

    always #5 clock = ~clock;

    register_universal #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .clock_enable (clock_enable),
        .mode         (mode),
        .byte_en      (byte_en),
        .d            (d),
        .serial_in    (serial_in),
`ifdef REGISTER_UNIVERSAL_SHADOW_EN
        .save         (save),
        .restore      (restore),
`endif
        .q            (q),
        .carry_out    (carry_out),
        .zero         (zero)
    );

    register_universal #(.WIDTH(16), .RESET_VALUE(16'h1234)) dut_rv (
        .clock        (clock),
        .clear_n      (clear_n),
        .clock_enable (clock_enable),
        .mode         (mode),
        .byte_en      (byte_en),
        .d            (d),
        .serial_in    (serial_in),
`ifdef REGISTER_UNIVERSAL_SHADOW_EN
        .save         (save),
        .restore      (restore),
`endif
        .q            (q1),
        .carry_out    (carry_out1),
        .zero         (zero1)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
    task automatic step(input string tag, input logic clr, input logic ce, input logic [2:0] m,
                        input logic [15:0] dd, input logic [1:0] be, input logic si,
                        input logic [15:0] eq, input logic ec);
        exp_t e;
        clear_n      = clr;
        clock_enable = ce;
        mode         = m;
        d            = dd;
        byte_en      = be;
        serial_in    = si;
        e.tag = tag;
        e.q   = eq;
        e.c   = ec;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_word({e.tag, ".q"}, q, e.q);
            check_bit({e.tag, ".carry"}, carry_out, e.c);
            check_bit({e.tag, ".zero"}, zero, (e.q == 16'h0000));
        end
    endtask

    initial begin
        clear_n = 1'b1; clock_enable = 1'b0; mode = HOLD; d = '0; byte_en = '0; serial_in = 1'b0;
        @(posedge clock);
        #1;

        step("reset", 1'b0, 1'b0, HOLD, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0);
        check_word("reset_rv.q", q1, 16'h1234);
        check_bit("reset_rv.zero", zero1, 1'b0);

        step("load_full", 1'b1, 1'b1, LOAD, 16'hABCD, 2'b11, 1'b0, 16'hABCD, 1'b0);
        step("load_lane0", 1'b1, 1'b1, LOAD, 16'h0011, 2'b01, 1'b0, 16'hAB11, 1'b0);
        step("load_ffff", 1'b1, 1'b1, LOAD, 16'hFFFF, 2'b11, 1'b0, 16'hFFFF, 1'b0);
        step("inc_wrap", 1'b1, 1'b1, INC, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b1);
        step("dec_wrap", 1'b1, 1'b1, DEC, 16'h0000, 2'b00, 1'b0, 16'hFFFF, 1'b1);
        step("dec", 1'b1, 1'b1, DEC, 16'h0000, 2'b00, 1'b0, 16'hFFFE, 1'b0);
        step("load_8001", 1'b1, 1'b1, LOAD, 16'h8001, 2'b11, 1'b0, 16'h8001, 1'b0);
        step("shl", 1'b1, 1'b1, SHL, 16'h0000, 2'b00, 1'b0, 16'h0002, 1'b1);
        step("ror1", 1'b1, 1'b1, ROR, 16'h0000, 2'b00, 1'b0, 16'h0001, 1'b0);
        step("ror2", 1'b1, 1'b1, ROR, 16'h0000, 2'b00, 1'b0, 16'h8000, 1'b1);
        step("shr", 1'b1, 1'b1, SHR, 16'h0000, 2'b00, 1'b1, 16'hC000, 1'b0);
        step("shl2", 1'b1, 1'b1, SHL, 16'h0000, 2'b00, 1'b0, 16'h8000, 1'b1);
        step("load_none", 1'b1, 1'b1, LOAD, 16'h1234, 2'b00, 1'b0, 16'h8000, 1'b0);
        step("rol", 1'b1, 1'b1, ROL, 16'h0000, 2'b00, 1'b0, 16'h0001, 1'b1);
        step("hold", 1'b1, 1'b1, HOLD, 16'h5555, 2'b11, 1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("ce_off", 1'b1, 1'b0, INC, 16'h0000, 2'b11, 1'b0, 16'h0001, 1'b1);
        end
        step("inc", 1'b1, 1'b1, INC, 16'h0000, 2'b00, 1'b0, 16'h0002, 1'b0);
        step("clear_mid", 1'b0, 1'b1, INC, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0);
        step("inc_after", 1'b1, 1'b1, INC, 16'h0000, 2'b00, 1'b0, 16'h0001, 1'b0);

`ifdef REGISTER_UNIVERSAL_SHADOW_EN
        step("sh_load1", 1'b1, 1'b1, LOAD, 16'h1111, 2'b11, 1'b0, 16'h1111, 1'b0);
        save = 1'b1;
        step("sh_save", 1'b1, 1'b1, HOLD, 16'h0000, 2'b00, 1'b0, 16'h1111, 1'b0);
        save = 1'b0;
        step("sh_load2", 1'b1, 1'b1, LOAD, 16'h2222, 2'b11, 1'b0, 16'h2222, 1'b0);
        save = 1'b1; restore = 1'b1;
        step("sh_swap", 1'b1, 1'b1, INC, 16'h0000, 2'b00, 1'b0, 16'h1111, 1'b0);
        save = 1'b0;
        step("sh_restore", 1'b1, 1'b1, INC, 16'h0000, 2'b00, 1'b0, 16'h2222, 1'b0);
        restore = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
